// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity encodings, baud arithmetic.
// No logic of its own; the receiver imports the same constants.
// BAUD_COUNT = CLK_FREQ / BAUD_RATE (integer divide, must be >= 2).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clock cycles per bit cell.
  function automatic int baud_count(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-cell timer: counts 0..BAUD_COUNT-1 and flags the last cycle of each cell.
// tick is combinational from the counter; wraps to 0 on the cycle after tick.
// No flow control; clear forces the counter to 0 synchronously (held while idle).
module uart_baud_gen #(
  parameter int BAUD_COUNT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(BAUD_COUNT);
  localparam logic [CW-1:0] LAST = CW'(BAUD_COUNT - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // Free-running cell counter, restarted by clear or at the end of each cell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
// Transfer at edge E into an idle block loads at E+1 with uartTx low from E+1; frames chain without gaps.
// dataReady = holding register empty; one byte may wait while the current frame shifts out.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int WIDTH     = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             dataValid,
  output logic             dataReady,
  output logic             uartTx,
  output logic             txBusy,
  output logic             txDone
);

  localparam int         BAUD_COUNT = baud_count(CLK_FREQ, BAUD_RATE);
  localparam logic [3:0] LAST_DATA  = 4'(WIDTH - 1);
  localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
  localparam bit         HAS_PARITY = (PARITY != PARITY_NONE);

  tx_state_t        state, state_next;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic [WIDTH-1:0] shifter, shifter_next;
  logic             parity_bit, parity_next;
  logic [3:0]       bit_count, bit_count_next;
  logic             tx_next, done_next;
  logic             load, transfer, tick, baud_clear;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic frame_parity(input logic [WIDTH-1:0] d);
    return (PARITY == PARITY_ODD) ? ~^d : ^d;
  endfunction

  // Ready depends only on the holding register, never on dataValid.
  assign dataReady  = !hold_full;
  assign transfer   = dataValid && !hold_full;
  assign txBusy     = (state != IDLE);
  // Holding the timer at 0 while idle makes every frame start on a clean cell.
  assign baud_clear = (state == IDLE);

  uart_baud_gen #(
    .BAUD_COUNT(BAUD_COUNT)
  ) u_baud_gen (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (tick)
  );

  // Holding register: filled by the handshake, emptied when the shifter loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (transfer) begin
      hold_full <= 1'b1;
      hold_data <= dataIn;
    end
  end

  // Next state, next line level and shifter update; the line is registered from tx_next.
  always_comb begin
    state_next     = state;
    shifter_next   = shifter;
    parity_next    = parity_bit;
    bit_count_next = bit_count;
    tx_next        = uartTx;
    done_next      = 1'b0;
    load           = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (hold_full) begin
          load = 1'b1;
        end
      end
      START_BIT: begin
        if (tick) begin
          state_next     = DATA_BITS;
          bit_count_next = '0;
          tx_next        = shifter[0];
        end
      end
      DATA_BITS: begin
        if (tick) begin
          if (bit_count == LAST_DATA) begin
            bit_count_next = '0;
            if (HAS_PARITY) begin
              state_next = PARITY_BIT;
              tx_next    = parity_bit;
            end else begin
              state_next = STOP_BIT;
              tx_next    = 1'b1;
            end
          end else begin
            bit_count_next = bit_count + 4'd1;
            shifter_next   = {1'b0, shifter[WIDTH-1:1]};
            tx_next        = shifter[1];
          end
        end
      end
      PARITY_BIT: begin
        if (tick) begin
          state_next     = STOP_BIT;
          bit_count_next = '0;
          tx_next        = 1'b1;
        end
      end
      STOP_BIT: begin
        if (tick) begin
          if (bit_count == LAST_STOP) begin
            done_next = 1'b1;
            tx_next   = 1'b1;
            if (hold_full) begin
              load = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_count_next = bit_count + 4'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
    // A load from IDLE or from the final stop tick starts the next frame at once.
    if (load) begin
      state_next     = START_BIT;
      shifter_next   = hold_data;
      parity_next    = frame_parity(hold_data);
      bit_count_next = '0;
      tx_next        = 1'b0;
    end
  end

  // FSM state, datapath and registered outputs; reset drives the line high immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shifter    <= '0;
      parity_bit <= 1'b0;
      bit_count  <= '0;
      uartTx     <= 1'b1;
      txDone     <= 1'b0;
    end else begin
      state      <= state_next;
      shifter    <= shifter_next;
      parity_bit <= parity_next;
      bit_count  <= bit_count_next;
      uartTx     <= tx_next;
      txDone     <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four configurations (8N1, 8E1, 8O1, 7N2) at 16 cycles per bit.
// Directed and random bytes are compared cycle by cycle against a frame-timeline model.
// Also covers reset in the middle of a frame and back-to-back chaining with dataValid held high.
module tb_uart_transmitter;

  localparam int BC = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0][8:0] din;
  logic [3:0]      vld, rdy, tx, busy, done;

  int vectors     = 0;
  int miscompares = 0;

  logic [8:0] script_q[$];

  always #5 clk = ~clk;

  uart_transmitter #(.CLK_FREQ(16), .BAUD_RATE(1), .WIDTH(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset(rst), .dataIn(din[0][7:0]), .dataValid(vld[0]), .dataReady(rdy[0]),
    .uartTx(tx[0]), .txBusy(busy[0]), .txDone(done[0]));
  uart_transmitter #(.CLK_FREQ(16), .BAUD_RATE(1), .WIDTH(8), .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .reset(rst), .dataIn(din[1][7:0]), .dataValid(vld[1]), .dataReady(rdy[1]),
    .uartTx(tx[1]), .txBusy(busy[1]), .txDone(done[1]));
  uart_transmitter #(.CLK_FREQ(16), .BAUD_RATE(1), .WIDTH(8), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .reset(rst), .dataIn(din[2][7:0]), .dataValid(vld[2]), .dataReady(rdy[2]),
    .uartTx(tx[2]), .txBusy(busy[2]), .txDone(done[2]));
  uart_transmitter #(.CLK_FREQ(16), .BAUD_RATE(1), .WIDTH(7), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .reset(rst), .dataIn(din[3][6:0]), .dataValid(vld[3]), .dataReady(rdy[3]),
    .uartTx(tx[3]), .txBusy(busy[3]), .txDone(done[3]));

  function automatic int cfg_w(input int k);
    return (k == 3) ? 7 : 8;
  endfunction
  function automatic int cfg_p(input int k);
    return (k == 1) ? 2 : ((k == 2) ? 1 : 0);
  endfunction
  function automatic int cfg_s(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Level of bit cell idx of a frame carrying d: start, data LSB first, parity, stop.
  function automatic logic exp_bit(input int k, input logic [8:0] d, input int idx);
    int w;
    w = cfg_w(k);
    if (idx == 0) return 1'b0;
    if (idx <= w) return d[idx-1];
    if (cfg_p(k) != 0 && idx == w + 1)
      return (($countones(d) % 2) == 1) ^ (cfg_p(k) == 1);
    return 1'b1;
  endfunction

  // Offers the scripted bytes then n_rand random ones to instance k and checks every cycle.
  // Model: a byte accepted at edge A starts at S = max(end of previous frame, A+1),
  // occupies nb*BC cycles, txDone is high in cycle S+nb*BC, ready is low in cycles A..S-1.
  task automatic run_stream(input int k, input int n_rand);
    int         w, nb, flen, f_last, a_last, s_last, remaining, total;
    int         fs[$];
    logic [8:0] fd[$];
    logic       tr[$];
    logic       offering, finished;
    logic [8:0] cur, mask, dec;
    logic       e_tx, e_busy, e_done, e_rdy;
    w        = cfg_w(k);
    nb       = 1 + w + ((cfg_p(k) != 0) ? 1 : 0) + cfg_s(k);
    flen     = nb * BC;
    mask     = 9'((1 << w) - 1);
    f_last   = -100;
    a_last   = -1;
    s_last   = -1;
    offering = 1'b0;
    finished = 1'b0;
    cur      = '0;
    total    = script_q.size() + n_rand;
    remaining = total;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      e_tx   = 1'b1;
      e_busy = 1'b0;
      e_done = 1'b0;
      foreach (fs[i]) begin
        if (c >= fs[i] && c < fs[i] + flen) begin
          e_busy = 1'b1;
          e_tx   = exp_bit(k, fd[i], (c - fs[i]) / BC);
        end
        if (c == fs[i] + flen) e_done = 1'b1;
      end
      e_rdy = !(c >= a_last && c < s_last);
      tr.push_back(tx[k]);
      check_eq("uartTx", 32'(tx[k]), 32'(e_tx));
      check_eq("txBusy", 32'(busy[k]), 32'(e_busy));
      check_eq("txDone", 32'(done[k]), 32'(e_done));
      check_eq("dataReady", 32'(rdy[k]), 32'(e_rdy));
      if (!offering && remaining > 0) begin
        if (script_q.size() > 0) begin
          cur = script_q.pop_front();
          offering = 1'b1;
          remaining--;
        end else if ($urandom_range(0, 2) != 0) begin
          cur = 9'($urandom);
          offering = 1'b1;
          remaining--;
        end
      end
      vld[k] = offering;
      din[k] = offering ? cur : 9'($urandom);
      if (offering && e_rdy) begin
        a_last = c + 1;
        s_last = (f_last > a_last + 1) ? f_last : a_last + 1;
        fs.push_back(s_last);
        fd.push_back(cur & mask);
        f_last   = s_last + flen;
        offering = 1'b0;
      end
      if (remaining == 0 && !offering && c > f_last + 1) begin
        finished = 1'b1;
        break;
      end
    end
    vld[k] = 1'b0;
    check_eq("stream_finished", 32'(finished), 32'd1);
    check_eq("frame_count", 32'(fs.size()), 32'(total));
    // Decode the recorded line at mid-cell and compare with the bytes handed over.
    foreach (fs[i]) begin
      dec = '0;
      for (int b = 0; b < w; b++) dec[b] = tr[fs[i] + BC * (1 + b) + BC / 2];
      check_eq("decoded_byte", 32'(dec), 32'(fd[i]));
    end
  endtask

  // Reset pulse in the middle of data bit 3 of a frame on instance 0.
  task automatic reset_midframe();
    int done_cnt, low_cnt, busy_cnt;
    @(negedge clk);
    check_eq("rst_pre_ready", 32'(rdy[0]), 32'd1);
    vld[0] = 1'b1;
    din[0] = 9'h034;
    @(negedge clk);
    vld[0] = 1'b0;
    din[0] = 9'h1FF;
    repeat (1 + 4 * BC + BC / 2) @(negedge clk);
    check_eq("pre_reset_line", 32'(tx[0]), 32'd0);
    check_eq("pre_reset_busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("reset_line_async", 32'(tx[0]), 32'd1);
    check_eq("reset_busy_async", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    low_cnt  = 0;
    busy_cnt = 0;
    repeat (3 * BC) begin
      @(negedge clk);
      if (done[0]) done_cnt++;
      if (!tx[0]) low_cnt++;
      if (busy[0]) busy_cnt++;
    end
    check_eq("post_reset_ready", 32'(rdy[0]), 32'd1);
    check_eq("post_reset_done_pulses", 32'(done_cnt), 32'd0);
    check_eq("post_reset_line_low", 32'(low_cnt), 32'd0);
    check_eq("post_reset_busy", 32'(busy_cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    vld = '0;
    din = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_uartTx", 32'(tx), 32'hF);
    check_eq("reset_txBusy", 32'(busy), 32'h0);
    check_eq("reset_txDone", 32'(done), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("release_dataReady", 32'(rdy), 32'hF);
    check_eq("release_uartTx", 32'(tx), 32'hF);

    script_q = '{9'h055};
    run_stream(0, 0);
    script_q = '{9'h0A3, 9'h00F};
    run_stream(0, 0);
    script_q = '{9'h022, 9'h011};
    run_stream(0, 6);
    script_q = '{9'h007};
    run_stream(1, 6);
    script_q = '{9'h007};
    run_stream(2, 6);
    script_q = '{9'h07F};
    run_stream(3, 6);
    reset_midframe();
    script_q = '{9'h096};
    run_stream(0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
